// File: rtl/deco_pkg.sv
// deco_pkg: shared types and helpers for the 2-to-4 pulse-train decoder.
// Contents: state_t FSM encoding, ONEHOT_W, onehot_of() code->line decode.
package deco_pkg;

   typedef enum logic [1:0] {
      S_IDLE,
      S_PULSE,
      S_GAP,
      S_DONE
   } state_t;

   localparam int ONEHOT_W = 4;

   function automatic logic [ONEHOT_W-1:0] onehot_of(
      input logic [1:0] c
   );
      onehot_of = ONEHOT_W'(1) << c;
   endfunction

endpackage

// File: rtl/deco_two_four_seq_if.sv
// deco_two_four_seq_if: start/ready/done handshake plus decoded outputs.
// master drives code/start; slave (the decoder) drives the status/outputs.
interface deco_two_four_seq_if;
   import deco_pkg::*;

   logic [1:0]          code;
   logic                start;
   logic                ready;
   logic                busy;
   logic                done;
   logic [ONEHOT_W-1:0] onehot;
   logic [1:0]          pulse_idx;

   modport master (
      output code,
      output start,
      input  ready,
      input  busy,
      input  done,
      input  onehot,
      input  pulse_idx
   );

   modport slave (
      input  code,
      input  start,
      output ready,
      output busy,
      output done,
      output onehot,
      output pulse_idx
   );

endinterface

// File: rtl/deco_timer.sv
// deco_timer: loadable down-counter shared by the pulse and gap phases.
// Ports: clk, rst (async high), load/load_val, en (decrement), zero flag.
module deco_timer #(
   parameter int CNT_W = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             load,
   input  logic [CNT_W-1:0] load_val,
   input  logic             en,
   output logic             zero
);

   logic [CNT_W-1:0] cnt;

   // Decrement stops at zero so the counter can never wrap.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt <= '0;
      end else if (load) begin
         cnt <= load_val;
      end else if (en && (cnt != '0)) begin
         cnt <= cnt - 1'b1;
      end
   end

   assign zero = (cnt == '0);

endmodule

// File: rtl/deco_two_four_seq.sv
// deco_two_four_seq: decodes a 2-bit code to one-hot and plays it as code+1 pulses.
// Ports: clk, rst (async high), bus (slave: code/start in; ready/busy/done/onehot/pulse_idx out).
module deco_two_four_seq
   import deco_pkg::*;
#(
   parameter int PULSE_LEN = 4,
   parameter int GAP_LEN   = 2,
   parameter int CNT_W     = 8
) (
   input  logic                 clk,
   input  logic                 rst,
   deco_two_four_seq_if.slave   bus
);

   localparam logic [CNT_W-1:0] P_LOAD = CNT_W'(PULSE_LEN - 1);
   localparam logic [CNT_W-1:0] G_LOAD = CNT_W'(GAP_LEN - 1);

   state_t           state;
   state_t           state_nxt;
   logic [1:0]       code_q;
   logic [1:0]       code_nxt;
   logic [1:0]       idx_q;
   logic [1:0]       idx_nxt;
   logic             t_load;
   logic [CNT_W-1:0] t_val;
   logic             t_en;
   logic             t_zero;

   deco_timer #(
      .CNT_W (CNT_W)
   ) u_timer (
      .clk      (clk),
      .rst      (rst),
      .load     (t_load),
      .load_val (t_val),
      .en       (t_en),
      .zero     (t_zero)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state  <= S_IDLE;
         code_q <= 2'd0;
         idx_q  <= 2'd0;
      end else begin
         state  <= state_nxt;
         code_q <= code_nxt;
         idx_q  <= idx_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      code_nxt  = code_q;
      idx_nxt   = idx_q;
      t_load    = 1'b0;
      t_val     = P_LOAD;
      t_en      = 1'b0;
      unique case (state)
         S_IDLE: begin
            if (bus.start) begin
               code_nxt  = bus.code;
               idx_nxt   = 2'd0;
               t_load    = 1'b1;
               t_val     = P_LOAD;
               state_nxt = S_PULSE;
            end
         end
         S_PULSE: begin
            if (t_zero) begin
               // Last pulse ends the run directly, no trailing gap.
               if (idx_q == code_q) begin
                  state_nxt = S_DONE;
               end else begin
                  t_load    = 1'b1;
                  t_val     = G_LOAD;
                  state_nxt = S_GAP;
               end
            end else begin
               t_en = 1'b1;
            end
         end
         S_GAP: begin
            if (t_zero) begin
               idx_nxt   = idx_q + 2'd1;
               t_load    = 1'b1;
               t_val     = P_LOAD;
               state_nxt = S_PULSE;
            end else begin
               t_en = 1'b1;
            end
         end
         S_DONE: begin
            state_nxt = S_IDLE;
         end
         default: begin
            state_nxt = S_IDLE;
         end
      endcase
   end

   logic in_run;
   assign in_run = (state == S_PULSE) || (state == S_GAP);

   assign bus.ready     = (state == S_IDLE);
   assign bus.busy      = in_run;
   assign bus.done      = (state == S_DONE);
   assign bus.onehot    = (state == S_PULSE) ? onehot_of(code_q) : '0;
   assign bus.pulse_idx = in_run ? idx_q : 2'd0;

endmodule

// File: tb/tb_deco_two_four_seq.sv
// tb_deco_two_four_seq: scoreboard bench for the 2-to-4 pulse-train decoder.
// Expected per-cycle outputs are queued at stimulus time and popped on negedge.
module tb_deco_two_four_seq;

   localparam int P = 4;
   localparam int G = 2;

   logic clk = 1'b0;
   logic rst = 1'b0;

   deco_two_four_seq_if bus ();

   deco_two_four_seq #(
      .PULSE_LEN (P),
      .GAP_LEN   (G),
      .CNT_W     (8)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   int n_cmp = 0;
   int n_bad = 0;
   logic mon_en = 1'b0;

   // {ready, busy, done, onehot[3:0], pulse_idx[1:0]}
   logic [8:0] sb[$];

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
      end
   endtask

   function automatic logic [8:0] outs();
      return {bus.ready, bus.busy, bus.done, bus.onehot, bus.pulse_idx};
   endfunction

   always @(negedge clk) begin
      if (mon_en && (sb.size() > 0)) begin
         logic [8:0] e;
         e = sb.pop_front();
         chk("seq", 32'(outs()), 32'(e));
      end
   end

   // Lead idle cycle (start presented), pulses/gaps, done, then tail idles.
   task automatic push_run(input logic [1:0] c, input int tail);
      logic [3:0] oh;
      oh = 4'b0001 << c;
      sb.push_back({1'b1, 1'b0, 1'b0, 4'b0000, 2'd0});
      for (int k = 0; k <= int'(c); k++) begin
         for (int i = 0; i < P; i++)
            sb.push_back({1'b0, 1'b1, 1'b0, oh, 2'(k)});
         if (k < int'(c))
            for (int i = 0; i < G; i++)
               sb.push_back({1'b0, 1'b1, 1'b0, 4'b0000, 2'(k)});
      end
      sb.push_back({1'b0, 1'b0, 1'b1, 4'b0000, 2'd0});
      for (int i = 0; i < tail; i++)
         sb.push_back({1'b1, 1'b0, 1'b0, 4'b0000, 2'd0});
   endtask

   task automatic start_run(input logic [1:0] c, input int tail);
      @(posedge clk);
      #1;
      bus.code  = c;
      bus.start = 1'b1;
      push_run(c, tail);
      @(posedge clk);
      #1;
      bus.start = 1'b0;
   endtask

   task automatic wait_empty(input int budget);
      int n;
      n = 0;
      while ((sb.size() > 0) && (n < budget)) begin
         @(posedge clk);
         n++;
      end
      if (sb.size() > 0) begin
         chk("timeout", 32'(sb.size()), 32'd0);
         sb.delete();
      end
   endtask

   initial begin
      bus.code  = 2'd0;
      bus.start = 1'b0;

      // 1: asynchronous reset, no clock edge in between
      #2;
      rst = 1'b1;
      #1;
      chk("rst_ready", 32'(bus.ready), 32'd1);
      chk("rst_busy", 32'(bus.busy), 32'd0);
      chk("rst_done", 32'(bus.done), 32'd0);
      chk("rst_onehot", 32'(bus.onehot), 32'd0);
      chk("rst_idx", 32'(bus.pulse_idx), 32'd0);
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b0;
      mon_en = 1'b1;

      // 2: code=2
      start_run(2'd2, 1);
      wait_empty(100);

      // 3: code=0
      start_run(2'd0, 1);
      wait_empty(100);

      // 4: code=3 with stray starts and code change mid-run
      start_run(2'd3, 2);
      @(posedge clk);
      #1;
      bus.start = 1'b1;
      bus.code  = 2'd1;
      @(posedge clk);
      #1;
      bus.start = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      bus.start = 1'b1;
      @(posedge clk);
      #1;
      bus.start = 1'b0;
      repeat (17) @(posedge clk);
      #1;
      chk("t4_in_done", 32'(bus.done), 32'd1);
      bus.start = 1'b1;
      @(posedge clk);
      #1;
      bus.start = 1'b0;
      wait_empty(100);

      // 5: code=1, reset during second pulse
      start_run(2'd1, 0);
      repeat (7) @(posedge clk);
      #1;
      chk("t5_pulse2", 32'(bus.onehot), 32'b0010);
      chk("t5_idx2", 32'(bus.pulse_idx), 32'd1);
      #1;
      rst = 1'b1;
      mon_en = 1'b0;
      sb.delete();
      #1;
      chk("t5_rst_out", 32'(outs()), 32'h100);
      repeat (3) begin
         @(negedge clk);
         chk("t5_no_done", 32'(bus.done), 32'd0);
      end
      @(posedge clk);
      #1;
      rst = 1'b0;
      mon_en = 1'b1;
      repeat (2) begin
         @(negedge clk);
         chk("t5_idle", 32'(outs()), 32'h100);
      end
      start_run(2'd1, 1);
      wait_empty(100);

      // 6: start held high, code=1 -> two back-to-back runs
      @(posedge clk);
      #1;
      bus.code  = 2'd1;
      bus.start = 1'b1;
      push_run(2'd1, 0);
      push_run(2'd1, 2);
      repeat (13) @(posedge clk);
      #1;
      bus.start = 1'b0;
      wait_empty(100);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

endmodule
